// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine: one NB-column state per transfer,
// COLS_PER_CYCLE columns transformed per clock, direction chosen per transfer.
module mix_columns_seq #(
  parameter int unsigned NB             = 4,
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_inverse,
  input  logic [0:32*NB-1] state_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:32*NB-1] state_out
);

  localparam int unsigned NumSteps = NB / COLS_PER_CYCLE;
  localparam int unsigned CntW     = (NumSteps > 1) ? $clog2(NumSteps) : 1;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : gen_nb_check
    $error("mix_columns_seq: NB must be 4, 6 or 8");
  end
  if (COLS_PER_CYCLE == 0 || (NB % COLS_PER_CYCLE) != 0) begin : gen_cpc_check
    $error("mix_columns_seq: COLS_PER_CYCLE must divide NB");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              st_q, st_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                inv_q, inv_d;
  logic [0:32*NB-1]    work_q, work_d;
  logic [0:32*NB-1]    res_q, res_d;
  logic                accept;
  logic [31:0]         col_in, col_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Column word holds row 0 in bits [31:24].
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] x1 [4];
    logic [7:0] x2 [4];
    logic [7:0] x3 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x1[i] = col[31-8*i -: 8];
      x2[i] = xtime(x1[i]);
      x3[i] = x2[i] ^ x1[i];
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (inv) begin
        r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                       ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ x1[(i+1)%4])
                       ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ x1[(i+2)%4])
                       ^ (x8[(i+3)%4] ^ x1[(i+3)%4]);
      end else begin
        r[31-8*i -: 8] = x2[i] ^ x3[(i+1)%4] ^ x1[(i+2)%4] ^ x1[(i+3)%4];
      end
    end
    return r;
  endfunction

  assign in_ready  = (st_q == StIdle) || ((st_q == StDone) && out_ready);
  assign out_valid = (st_q == StDone);
  assign state_out = res_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    work_d  = work_q;
    res_d   = res_q;
    col_in  = '0;
    col_out = '0;

    unique case (st_q)
      StIdle: ;
      StBusy: begin
        // Constant-index muxes keep only COLS_PER_CYCLE column transforms in hardware.
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
          col_in = '0;
          for (int unsigned s = 0; s < NumSteps; s++) begin
            if (cnt_q == CntW'(s)) col_in = work_q[(s*COLS_PER_CYCLE+j)*32 +: 32];
          end
          col_out = mix_col(col_in, inv_q);
          for (int unsigned s = 0; s < NumSteps; s++) begin
            if (cnt_q == CntW'(s)) res_d[(s*COLS_PER_CYCLE+j)*32 +: 32] = col_out;
          end
        end
        if (cnt_q == CntW'(NumSteps - 1)) begin
          cnt_d = '0;
          st_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase

    // Acceptance overrides DONE->IDLE so back-to-back transfers skip IDLE.
    if (accept) begin
      work_d = state_in;
      inv_d  = in_inverse;
      cnt_d  = '0;
      st_d   = StBusy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= StIdle;
      cnt_q  <= '0;
      inv_q  <= 1'b0;
      work_q <= '0;
      res_q  <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      inv_q  <= inv_d;
      work_q <= work_d;
      res_q  <= res_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq across several NB / COLS_PER_CYCLE configurations.
module tb_mix_columns_seq;

  localparam logic [0:127] FwdIn  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [0:127] FwdOut = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [0:127] InvIn  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [0:127] InvOut = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic         c1_in_valid, c1_in_ready, c1_inv, c1_out_valid, c1_out_ready;
  logic [0:127] c1_in, c1_out;
  logic         c4_in_valid, c4_in_ready, c4_inv, c4_out_valid, c4_out_ready;
  logic [0:127] c4_in, c4_out;
  logic         c2_in_valid, c2_in_ready, c2_inv, c2_out_valid, c2_out_ready;
  logic [0:127] c2_in, c2_out;
  logic         n8_in_valid, n8_in_ready, n8_inv, n8_out_valid, n8_out_ready;
  logic [0:255] n8_in, n8_out;

  mix_columns_seq #(.NB(4), .COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
    .in_inverse(c1_inv), .state_in(c1_in), .out_valid(c1_out_valid),
    .out_ready(c1_out_ready), .state_out(c1_out)
  );
  mix_columns_seq #(.NB(4), .COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(c4_in_valid), .in_ready(c4_in_ready),
    .in_inverse(c4_inv), .state_in(c4_in), .out_valid(c4_out_valid),
    .out_ready(c4_out_ready), .state_out(c4_out)
  );
  mix_columns_seq #(.NB(4), .COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .in_valid(c2_in_valid), .in_ready(c2_in_ready),
    .in_inverse(c2_inv), .state_in(c2_in), .out_valid(c2_out_valid),
    .out_ready(c2_out_ready), .state_out(c2_out)
  );
  mix_columns_seq #(.NB(8), .COLS_PER_CYCLE(2)) u_n8 (
    .clk(clk), .rst_n(rst_n), .in_valid(n8_in_valid), .in_ready(n8_in_ready),
    .in_inverse(n8_inv), .state_in(n8_in), .out_valid(n8_out_valid),
    .out_ready(n8_out_ready), .state_out(n8_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer8(input logic [0:255] d, input logic inv, output logic [0:255] r,
                       output int lat);
    n8_in       = d;
    n8_inv      = inv;
    n8_in_valid = 1'b1;
    tick();
    n8_in_valid = 1'b0;
    n8_in       = '0;
    lat = 0;
    while (!n8_out_valid && lat < 50) begin
      tick();
      lat++;
    end
    r = n8_out;
    n8_out_ready = 1'b1;
    tick();
    n8_out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int gap;
    logic [0:255] d, f, b;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    {c1_in_valid, c1_inv, c1_out_ready} = '0;
    {c4_in_valid, c4_inv, c4_out_ready} = '0;
    {c2_in_valid, c2_inv, c2_out_ready} = '0;
    {n8_in_valid, n8_inv, n8_out_ready} = '0;
    c1_in = '0; c4_in = '0; c2_in = '0; n8_in = '0;
    #12 rst_n = 1'b1;
    tick();

    check("reset in_ready", c1_in_ready, 1);
    check("reset out_valid", c1_out_valid, 0);
    check("reset state_out", c1_out, 0);

    // Forward, one column per clock; inputs scrambled after acceptance.
    c1_in = FwdIn; c1_inv = 1'b0; c1_in_valid = 1'b1;
    tick();
    c1_in_valid = 1'b0; c1_in = '1; c1_inv = 1'b1;
    check("c1 busy in_ready", c1_in_ready, 0);
    lat = 0;
    while (!c1_out_valid && lat < 20) begin tick(); lat++; end
    check("c1 fwd latency", lat, 4);
    check("c1 fwd result", c1_out, FwdOut);

    // Backpressure with a pending source.
    c1_in = InvIn; c1_inv = 1'b1; c1_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp out_valid", c1_out_valid, 1);
      check("bp state_out", c1_out, FwdOut);
      check("bp in_ready", c1_in_ready, 0);
    end
    c1_in_valid = 1'b0;
    c1_out_ready = 1'b1;
    #1;
    check("done in_ready follows out_ready", c1_in_ready, 1);
    tick();
    check("drain out_valid", c1_out_valid, 0);
    check("drain idle in_ready", c1_in_ready, 1);
    c1_out_ready = 1'b0;

    // Reset two cycles into BUSY.
    c1_in = InvIn; c1_inv = 1'b1; c1_in_valid = 1'b1;
    tick();
    c1_in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst out_valid", c1_out_valid, 0);
    check("rst state_out", c1_out, 0);
    check("rst in_ready", c1_in_ready, 1);
    #2 rst_n = 1'b1;
    tick();
    c1_in = InvIn; c1_inv = 1'b1; c1_in_valid = 1'b1;
    tick();
    c1_in_valid = 1'b0;
    lat = 0;
    while (!c1_out_valid && lat < 20) begin tick(); lat++; end
    check("c1 post-reset latency", lat, 4);
    check("c1 post-reset inv result", c1_out, InvOut);
    c1_out_ready = 1'b1;
    tick();
    c1_out_ready = 1'b0;

    // Inverse, whole state in one clock.
    c4_in = InvIn; c4_inv = 1'b1; c4_in_valid = 1'b1;
    tick();
    c4_in_valid = 1'b0; c4_in = '0; c4_inv = 1'b0;
    lat = 0;
    while (!c4_out_valid && lat < 20) begin tick(); lat++; end
    check("c4 inv latency", lat, 1);
    check("c4 inv result", c4_out, InvOut);
    c4_out_ready = 1'b1;
    tick();
    c4_out_ready = 1'b0;

    // Back-to-back: forward then inverse of that result.
    c2_out_ready = 1'b1;
    c2_in = FwdIn; c2_inv = 1'b0; c2_in_valid = 1'b1;
    tick();
    c2_in_valid = 1'b0;
    lat = 0;
    while (!c2_out_valid && lat < 20) begin tick(); lat++; end
    check("c2 fwd latency", lat, 2);
    check("c2 fwd result", c2_out, FwdOut);
    c2_in = c2_out; c2_inv = 1'b1; c2_in_valid = 1'b1;
    #1;
    check("c2 done in_ready", c2_in_ready, 1);
    tick();
    c2_in_valid = 1'b0; c2_in = '0;
    check("c2 b2b busy in_ready", c2_in_ready, 0);
    check("c2 b2b busy out_valid", c2_out_valid, 0);
    gap = 1;
    while (!c2_out_valid && gap < 20) begin tick(); gap++; end
    check("c2 b2b spacing", gap, 3);
    check("c2 round trip", c2_out, FwdIn);
    tick();
    check("c2 back to idle", c2_out_valid, 0);
    c2_out_ready = 1'b0;

    // Eight-column state, two columns per clock, forward/inverse round trips.
    for (int t = 0; t < 1000; t++) begin
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
      xfer8(d, 1'b0, f, lat);
      check("n8 fwd latency", lat, 4);
      xfer8(f, 1'b1, b, lat);
      check("n8 inv latency", lat, 4);
      check("n8 round trip", b, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
